// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hEAFF_FFFE;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus8;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc_plus8: 32'h0,
        valid:    1'b0
    };

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with flush (bubble) and stall (hold) control.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= IF_ID_BUBBLE;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, next-PC selection, range check, halt/fault FSM.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] HALT_WORD  = HALT_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_taken_e,
    input  logic [31:0] branch_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus8_d,
    output logic        valid_d,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

    fetch_state_e state;
    logic [31:0]  pc_plus4;
    logic         target_bad;
    logic         seq_bad;
    logic         halt_seen;
    if_id_t       if_id_d;
    if_id_t       if_id_q;

    assign imem_addr  = pc_f;
    assign pc_plus4   = pc_f + 32'd4;
    assign target_bad = (branch_target_e[1:0] != 2'b00)
                     || (branch_target_e >= LIMIT);
    assign seq_bad    = pc_plus4 >= LIMIT;
    assign halt_seen  = !stall_d && !flush_d
                     && (imem_instr == HALT_WORD);

    always_comb begin
        if_id_d = IF_ID_BUBBLE;
        if (state == RUN) begin
            if_id_d.instr    = imem_instr;
            if_id_d.pc_plus8 = pc_f + 32'd8;
            if_id_d.valid    = 1'b1;
        end
    end

    // Redirect outranks halt detection: a halt on the redirected-from path is squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            pc_f   <= RESET_PC;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (branch_taken_e) begin
                        if (target_bad) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc_f <= branch_target_e;
                        end
                    end else if (halt_seen) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (!stall_f) begin
                        if (seq_bad) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc_f <= pc_plus4;
                        end
                    end
                end
                HALT: begin
                    if (branch_taken_e) begin
                        halted <= 1'b0;
                        if (target_bad) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= RUN;
                            pc_f  <= branch_target_e;
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state  <= FAULT;
                    halted <= 1'b0;
                    fault  <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .stall (stall_d),
        .flush (flush_d),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign instr_d    = if_id_q.instr;
    assign pc_plus8_d = if_id_q.pc_plus8;
    assign valid_d    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 64-word async ROM model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        branch_taken_e;
    logic [31:0] branch_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_plus8_d;
    logic        valid_d;
    logic        halted;
    logic        fault;

    logic [31:0] mem [64];
    int total = 0;
    int bad   = 0;

    localparam logic [31:0] HALT_W = 32'hEAFF_FFFE;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[7:2]];

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .branch_taken_e  (branch_taken_e),
        .branch_target_e (branch_target_e),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .pc_f            (pc_f),
        .instr_d         (instr_d),
        .pc_plus8_d      (pc_plus8_d),
        .valid_d         (valid_d),
        .halted          (halted),
        .fault           (fault)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst = 1'b1;
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        branch_taken_e = 1'b0;
        branch_target_e = 32'h0;
        step();
        step();
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_instr", instr_d, 32'h0);
        chk("rst_pc8", pc_plus8_d, 32'h0);
        chk("rst_valid", {31'b0, valid_d}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // sequential fetch
        rst = 1'b0;
        step();
        chk("seq1_pc", pc_f, 32'h4);
        chk("seq1_instr", instr_d, 32'hA000_0000);
        chk("seq1_pc8", pc_plus8_d, 32'h8);
        chk("seq1_valid", {31'b0, valid_d}, 32'd1);
        step();
        chk("seq2_pc", pc_f, 32'h8);
        chk("seq2_instr", instr_d, 32'hA000_0001);
        chk("seq2_pc8", pc_plus8_d, 32'hC);
        step();
        step();
        chk("pre_stall_pc", pc_f, 32'h10);
        chk("pre_stall_instr", instr_d, 32'hA000_0003);

        // stall hold
        stall_f = 1'b1;
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_f, 32'h10);
            chk("stall_instr", instr_d, 32'hA000_0003);
            chk("stall_pc8", pc_plus8_d, 32'h14);
        end
        stall_f = 1'b0;
        stall_d = 1'b0;
        step();
        chk("rel_pc", pc_f, 32'h14);
        chk("rel_instr", instr_d, 32'hA000_0004);
        chk("rel_pc8", pc_plus8_d, 32'h18);

        // redirect beats stall, flush inserts bubble
        branch_taken_e = 1'b1;
        branch_target_e = 32'h20;
        stall_f = 1'b1;
        flush_d = 1'b1;
        step();
        chk("br_pc", pc_f, 32'h20);
        chk("br_valid", {31'b0, valid_d}, 32'd0);
        chk("br_instr", instr_d, 32'h0);
        branch_taken_e = 1'b0;
        stall_f = 1'b0;
        flush_d = 1'b0;
        step();
        chk("br_pc2", pc_f, 32'h24);
        chk("br_instr2", instr_d, 32'hA000_0008);
        chk("br_pc8", pc_plus8_d, 32'h28);
        chk("br_valid2", {31'b0, valid_d}, 32'd1);

        // flush beats stall_d
        stall_d = 1'b1;
        flush_d = 1'b1;
        step();
        chk("fl_st_valid", {31'b0, valid_d}, 32'd0);
        stall_d = 1'b0;
        flush_d = 1'b0;

        // halt
        mem[5] = HALT_W;
        rst = 1'b1;
        step();
        chk("rst2_pc", pc_f, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("h_pre_pc", pc_f, 32'h14);
        step();
        chk("h_instr", instr_d, HALT_W);
        chk("h_valid", {31'b0, valid_d}, 32'd1);
        chk("h_pc8", pc_plus8_d, 32'h1C);
        chk("h_halted", {31'b0, halted}, 32'd1);
        chk("h_pc", pc_f, 32'h14);
        step();
        chk("h2_pc", pc_f, 32'h14);
        chk("h2_valid", {31'b0, valid_d}, 32'd0);
        chk("h2_halted", {31'b0, halted}, 32'd1);
        branch_taken_e = 1'b1;
        branch_target_e = 32'h0;
        step();
        chk("h_out_pc", pc_f, 32'h0);
        chk("h_out_halted", {31'b0, halted}, 32'd0);
        branch_taken_e = 1'b0;
        mem[5] = 32'hA000_0005;

        // misaligned redirect
        branch_taken_e = 1'b1;
        branch_target_e = 32'h102;
        flush_d = 1'b1;
        step();
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_pc", pc_f, 32'h0);
        chk("mis_valid", {31'b0, valid_d}, 32'd0);
        branch_target_e = 32'h8;
        flush_d = 1'b0;
        step();
        chk("abs_pc", pc_f, 32'h0);
        chk("abs_fault", {31'b0, fault}, 32'd1);
        chk("abs_valid", {31'b0, valid_d}, 32'd0);
        branch_taken_e = 1'b0;
        rst = 1'b1;
        step();
        chk("clr_fault", {31'b0, fault}, 32'd0);
        chk("clr_pc", pc_f, 32'h0);
        rst = 1'b0;

        // out-of-range redirect
        branch_taken_e = 1'b1;
        branch_target_e = 32'h100;
        step();
        chk("oor_fault", {31'b0, fault}, 32'd1);
        chk("oor_pc", pc_f, 32'h0);
        branch_taken_e = 1'b0;
        step();
        chk("oor_valid", {31'b0, valid_d}, 32'd0);
        chk("oor_pc2", pc_f, 32'h0);

        // run off the end of the ROM
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 63; i++) step();
        chk("end_pc", pc_f, 32'hFC);
        chk("end_nofault", {31'b0, fault}, 32'd0);
        step();
        chk("end_fault", {31'b0, fault}, 32'd1);
        chk("end_pc2", pc_f, 32'hFC);
        chk("end_instr", instr_d, 32'hA000_003F);
        chk("end_pc8", pc_plus8_d, 32'h104);
        step();
        chk("end_pc3", pc_f, 32'hFC);
        chk("end_valid", {31'b0, valid_d}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
